// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, colour/timing structs and the position decoder
// used by the VGA scan driver.
package vga_timing_pkg;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_ACTIVE = 10'd640;
  localparam cnt_t H_FP     = 10'd16;
  localparam cnt_t H_SYNC   = 10'd96;
  localparam cnt_t H_TOTAL  = 10'd800;
  localparam cnt_t V_ACTIVE = 10'd480;
  localparam cnt_t V_FP     = 10'd10;
  localparam cnt_t V_SYNC   = 10'd2;
  localparam cnt_t V_TOTAL  = 10'd525;

  // Sync windows are half-open: [START, END)
  localparam cnt_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam cnt_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam cnt_t H_LAST       = H_TOTAL - 10'd1;
  localparam cnt_t V_LAST       = V_TOTAL - 10'd1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } timing_t;

  function automatic timing_t decode_position(input cnt_t h, input cnt_t v);
    timing_t t;
    t.active = (h < H_ACTIVE) && (v < V_ACTIVE);
    t.hs_n   = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    t.vs_n   = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    return t;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser for asynchronous inputs; only the second flop is
// visible to downstream logic.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// 640x480@60 VGA scan driver: pixel enable, raster counters, registered DAC/sync
// outputs and note synchroniser. Optional macro FRAME_NOTE_LATCH_EN holds notes until vblank.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] note_in,
  output logic [6:0] notes,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  cnt_t             hcnt;
  cnt_t             vcnt;
  timing_t          pos;
  rgb_t             pix_in;
  rgb_t             dac;
  logic             frame_origin;
  logic [6:0]       note_sync;

  // pix_en is high on every CLK_DIV-th clk, the first one CLK_DIV edges after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_en  = (div_cnt == DIV_LAST);
  assign vga_clk = ~pix_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign x            = hcnt;
  assign y            = vcnt[8:0];
  assign pos          = decode_position(hcnt, vcnt);
  assign pix_in       = '{r: r, g: g, b: b};
  assign frame_origin = (hcnt == '0) && (vcnt == '0);

  // Colour, syncs and blank all describe the same sampled pixel, one pixel behind x/y
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dac         <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_origin;
      if (pix_en) begin
        dac         <= pos.active ? pix_in : '0;
        vga_hs      <= pos.hs_n;
        vga_vs      <= pos.vs_n;
        vga_blank_n <= pos.active;
      end
    end
  end

  assign vga_r = dac.r;
  assign vga_g = dac.g;
  assign vga_b = dac.b;

  sync_2ff #(
    .WIDTH(7)
  ) u_note_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (note_in),
    .q       (note_sync)
  );

`ifdef FRAME_NOTE_LATCH_EN
  // Notes only change at the first vblank pixel so a frame is drawn from one snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      notes <= '0;
    end else if (pix_en && (hcnt == '0) && (vcnt == V_ACTIVE)) begin
      notes <= note_sync;
    end
  end
`else
  assign notes = note_sync;
`endif

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel; only 2 is supported, for 640x480@60 from 50 MHz.
REQ-002 SHALL have port clk, input, 1, system clock at 50 MHz.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port note_in, input, 7, raw asynchronous key levels, bit0=C through bit6=B.
REQ-005 SHALL have port notes, output, 7, synchronised note levels fed to the drawer, same bit order as note_in.
REQ-006 SHALL have port x, output, 10, current horizontal pixel count fed to the drawer.
REQ-007 SHALL have port y, output, 9, current vertical pixel count bits [8:0] fed to the drawer.
REQ-008 SHALL have ports r, g, b, input, 8 each, combinational pixel colour returned for the current (x, y).
REQ-009 SHALL have ports vga_r, vga_g, vga_b, output, 8 each, registered DAC colour.
REQ-010 SHALL have ports vga_hs, vga_vs, output, 1 each, active-low syncs.
REQ-011 SHALL have ports vga_blank_n, output, 1, high in active video; and vga_clk, output, 1, pixel clock.
REQ-012 SHALL have port frame_start, output, 1, one-clk pulse at the start of each frame.

Function
REQ-013 SHALL toggle internal pix_en every clk; pix_en is high on the 2nd, 4th, … clk edge after reset release; vga_clk = ~pix_en.
REQ-014 SHALL advance hcnt 0..799 on pix_en, wrapping 799->0; vcnt 0..524 SHALL increment on that wrap and itself wrap 524->0.
REQ-015 SHALL drive x = hcnt and y = vcnt[8:0] combinationally from the counters.
REQ-016 SHALL define active video as hcnt<640 and vcnt<480; sync low for hcnt 656..751 (hs) and vcnt 490..491 (vs).
REQ-017 SHALL register r/g/b, sync and blank together on pix_en, giving exactly one pixel of latency from x/y to the VGA pins.
REQ-018 SHALL force vga_r/g/b to 0 on a registered cycle when the sampled position is outside active video, regardless of r/g/b.
REQ-019 SHALL pass note_in through a two-flop synchroniser on clk.
REQ-020 SHALL pulse frame_start for one clk on the pix_en where hcnt=0 and vcnt=0.
REQ-021 SHALL make a note change shorter than 2 clk optional to observe, and SHALL NOT allow metastable values at notes.

Reset
REQ-022 SHALL, while reset_n is low: set hcnt=0, vcnt=0, pix_en=0, synchroniser and notes to 0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0.
REQ-023 SHALL restart at (0,0) after reset asserts mid-frame, with no partial sync pulse continuing after release.

Configuration
REQ-024 SHALL support macro FRAME_NOTE_LATCH_EN; when defined, notes SHALL update from the synchronised value only on the pix_en where hcnt=0 and vcnt=480 (start of vblank), so the picture never tears.
REQ-025 SHALL, without FRAME_NOTE_LATCH_EN, drive notes directly from the second synchroniser flop, giving a 2-clk delay.

Structure
REQ-026 SHALL take H_ACTIVE=640, H_FP=16, H_SYNC=96, H_TOTAL=800, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_TOTAL=525 from shared package vga_timing_pkg.
REQ-027 SHALL instantiate one sub-module, sync_2ff (parameterised width), for the note synchroniser.

Verification
REQ-028 SHALL cover reset: hold reset_n low 10 clk -> vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0, x=0, y=0; hcnt reaches 1 on the 2nd edge after release.
REQ-029 SHALL cover line timing: free-run -> vga_hs low for exactly 192 clk, period 1600 clk; vga_blank_n high for 1280 clk per line.
REQ-030 SHALL cover frame timing: free-run -> vga_vs low for 2 lines (3200 clk), frame_start period 840000 clk.
REQ-031 SHALL cover the pixel path: drawer model returns r=x[7:0] -> vga_r equals the previous pixel's x; all zero while vga_blank_n=0 even when r=8'hFF.
REQ-032 SHALL cover note latch: with FRAME_NOTE_LATCH_EN, toggle note_in[2] at (100,200) -> notes[2] changes only at (0,480); without the macro it changes 2 clk later.
REQ-033 SHALL cover reset mid-frame: assert reset_n at (700,491) -> vga_vs=1 immediately, and the next frame_start occurs 2 clk after release.
